// File: rtl/data_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_memory                                                  |
// | Description : Word-addressed single-port data RAM, registered read,        |
// |               write-first, per-word valid map cleared by async reset.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] dataOut
);

  localparam int c_depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [c_depth-1:0]    r_valid;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Array is never reset; a stray write during reset is masked because
  // r_valid stays cleared until reset is released.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[address] <= dataIn;
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (we) begin
      w_rd_data = dataIn;
    end else if (r_valid[address]) begin
      w_rd_data = r_mem[address];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      dataOut <= '0;
    end else begin
      if (we) begin
        r_valid[address] <= 1'b1;
      end
      dataOut <= w_rd_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_memory                                               |
// | Description : Scoreboard bench for data_memory: reference model pushes     |
// |               expected read data, a monitor pops it after each edge.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_data_memory;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;

  logic                  clk;
  logic                  rst;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  we;
  logic [DATA_WIDTH-1:0] dataOut;

  int n_checks;
  int n_fail;

  logic [DATA_WIDTH-1:0] exp_q [$];
  int                    addr_q [$];
  logic [DATA_WIDTH-1:0] model [int];

  data_memory #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .address(address),
    .dataIn (dataIn),
    .we     (we),
    .dataOut(dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs,
                       input logic [DATA_WIDTH-1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // One access per cycle; expected data comes from the associative-array model.
  task automatic drive(input int a, input logic [DATA_WIDTH-1:0] d, input logic w);
    logic [DATA_WIDTH-1:0] e;
    @(negedge clk);
    address = a[ADDR_WIDTH-1:0];
    dataIn  = d;
    we      = w;
    if (w) e = d;
    else if (model.exists(a)) e = model[a];
    else e = '0;
    if (w) model[a] = d;
    exp_q.push_back(e);
    addr_q.push_back(a);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [DATA_WIDTH-1:0] e;
      int a;
      e = exp_q.pop_front();
      a = addr_q.pop_front();
      check($sformatf("rd_addr%0d", a), dataOut, e);
    end
  end

  // Asserts reset mid-cycle, checks the immediate clear, then tries a write
  // while reset is held.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check({tag, "_async"}, dataOut, '0);
    address = 10'd7;
    dataIn  = 32'h0000_0077;
    we      = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_hold"}, dataOut, '0);
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
    model.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    address  = '0;
    dataIn   = '0;
    we       = 1'b0;

    #2;
    rst = 1'b1;
    #1;
    check("rst_initial", dataOut, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) drive(k, '0, 1'b0);
    drive(7, '0, 1'b0);

    for (int k = 0; k < 10; k++) drive(k, DATA_WIDTH'(k), 1'b1);
    for (int k = 0; k < 10; k++) drive(k, '0, 1'b0);

    drive(5, 32'hDEAD_BEEF, 1'b1);
    drive(5, '0, 1'b0);

    drive(3, 32'hFFFF_FFFF, 1'b0);
    drive(3, '0, 1'b0);

    drive(1023, 32'hA5A5_A5A5, 1'b1);
    drive(0, 32'h5A5A_5A5A, 1'b1);
    drive(1023, '0, 1'b0);
    drive(0, '0, 1'b0);

    drive(9, '0, 1'b0);
    reset_pulse("rst_mid");
    for (int k = 0; k < 10; k++) drive(k, '0, 1'b0);
    drive(4, 32'd44, 1'b1);
    drive(4, '0, 1'b0);
    drive(5, '0, 1'b0);

    @(negedge clk);
    we = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
